// File: rtl/pim_store_pkg.sv
// Shared definitions for the PIM store unloader.
// Contents:
//   - state_e      : unloader FSM states (IDLE, SEND).
//   - num_beats()  : number of W-bit beats needed to carry an N-bit word.
//   - cnt_width()  : beat counter width, never less than one bit.
//   - DEF_*        : default word/beat geometry and the matching counter width.
package pim_store_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  function automatic int num_beats(input int n, input int w);
    return (n + w - 1) / w;
  endfunction

  function automatic int cnt_width(input int nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

  localparam int DEF_N     = 10;
  localparam int DEF_W     = 4;
  localparam int DEF_CNT_W = cnt_width(num_beats(DEF_N, DEF_W));

endpackage

// File: rtl/pim_beat_mux.sv
// Beat selector: picks the W-bit chunk at index 'beat' out of an N-bit word.
// The word is zero-extended to NUM_BEATS*W bits, so any bit positions above
// N on the final beat read as 0.
// Ports:
//   word  in  N      captured PIM word
//   beat  in  CNT_W  beat index, 0..NUM_BEATS-1
//   data  out W      selected chunk
module pim_beat_mux #(
  parameter int N         = 10,
  parameter int W         = 4,
  parameter int NUM_BEATS = 3,
  parameter int CNT_W     = 2
) (
  input  logic [N-1:0]     word,
  input  logic [CNT_W-1:0] beat,
  output logic [W-1:0]     data
);

  logic [NUM_BEATS*W-1:0] padded;

  always_comb begin
    padded        = '0;
    padded[N-1:0] = word;
    data          = '0;
    // Compare against every legal index instead of a variable part-select so
    // an out-of-range index can never address past the padded vector.
    for (int b = 0; b < NUM_BEATS; b++) begin
      if (beat == CNT_W'(b)) begin
        data = padded[b*W +: W];
      end
    end
  end

endmodule

// File: rtl/pim_store_unloader.sv
// PIM store unloader: captures an N-bit PIM result word on PIM_store and
// streams it LSB chunk first as W-bit beats over a valid/ready interface.
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   D            in   N  PIM result word to store
//   PIM_store    in   capture request, sampled on clk
//   clr_overrun  in   synchronous clear of the overrun flag
//   out_data     out  W  current beat
//   out_valid    out  beat valid
//   out_ready    in   sink accepts beat
//   out_last     out  current beat is the final one
//   busy         out  word held / being streamed
//   done         out  one-cycle pulse after the final beat transfers
//   overrun      out  sticky: a capture request was dropped
module pim_store_unloader
  import pim_store_pkg::*;
#(
  parameter int N = 10,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] D,
  input  logic         PIM_store,
  input  logic         clr_overrun,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic         done,
  output logic         overrun
);

  localparam int NUM_BEATS = num_beats(N, W);
  localparam int CNT_W     = cnt_width(NUM_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  state_e           state_q,   state_d;
  logic [N-1:0]     shadow_q,  shadow_d;
  logic [CNT_W-1:0] beat_q,    beat_d;
  logic             done_q,    done_d;
  logic             overrun_q, overrun_d;

  logic             xfer;
  logic             last_xfer;
  logic             drop;
  logic [W-1:0]     mux_data;

  assign xfer      = (state_q == SEND) && out_ready;
  assign last_xfer = xfer && (beat_q == LAST_BEAT);
  // A request is only accepted in IDLE or in the cycle the final beat leaves.
  assign drop      = (state_q == SEND) && PIM_store && !last_xfer;

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    beat_d    = beat_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (PIM_store) begin
          shadow_d = D;
          beat_d   = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (last_xfer) begin
          done_d = 1'b1;
          beat_d = '0;
          if (PIM_store) begin
            // Back-to-back capture: stay in SEND with no idle bubble.
            shadow_d = D;
          end else begin
            state_d = IDLE;
          end
        end else if (xfer) begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Set has priority over clear so a drop in the clear cycle is not lost.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      beat_q    <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      beat_q    <= beat_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  pim_beat_mux #(
    .N         (N),
    .W         (W),
    .NUM_BEATS (NUM_BEATS),
    .CNT_W     (CNT_W)
  ) u_beat_mux (
    .word (shadow_q),
    .beat (beat_q),
    .data (mux_data)
  );

  assign out_valid = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign out_last  = (state_q == SEND) && (beat_q == LAST_BEAT);
  assign out_data  = (state_q == SEND) ? mux_data : '0;
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule
